// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bits captured after the start bit: d0..d7, parity, stop.
  localparam int FRAME_DATA_BITS = 10;
  localparam int STOP_IDX        = 9;

endpackage

// File: rtl/ps2_clk_filter.sv
// Synchronizes ps2c, debounces it over FILTER_LEN samples and flags falling edges.
module ps2_clk_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic ps2c,
  output logic filt_c,
  output logic fall
);

  logic [1:0]            r_sync;
  logic [FILTER_LEN-1:0] r_shift;
  logic                  r_filt_c;
  logic                  r_filt_prev;

  // Everything resets to the idle-high bus level so reset never fakes an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync      <= '1;
      r_shift     <= '1;
      r_filt_c    <= 1'b1;
      r_filt_prev <= 1'b1;
    end else begin
      // NOTE: non-blocking so each flop samples its predecessor's pre-edge value.
      r_sync      <= {r_sync[0], ps2c};
      r_shift     <= {r_shift[FILTER_LEN-2:0], r_sync[1]};
      if (&r_shift)
        r_filt_c <= 1'b1;
      else if (~|r_shift)
        r_filt_c <= 1'b0;
      r_filt_prev <= r_filt_c;
    end
  end

  assign filt_c = r_filt_c;
  assign fall   = r_filt_prev & ~r_filt_c;

endmodule

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: one byte per frame with parity, framing and timeout status.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int TO_W           = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2c,
  input  logic       ps2d,
  input  logic       rx_en,
  output logic [7:0] dout,
  output logic       rx_done_tick,
  output logic       parity_err,
  output logic       frame_err,
  output logic       timeout_tick,
  output logic       busy
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]      STOP_CNT = 4'(STOP_IDX);

  logic                       w_fall;
  logic                       w_data;
  logic [1:0]                 r_d_sync;

  state_t                     r_state,      w_state_n;
  logic [3:0]                 r_bit_cnt,    w_bit_cnt_n;
  logic [FRAME_DATA_BITS-1:0] r_sr,         w_sr_n;
  logic [TO_W-1:0]            r_to_cnt,     w_to_cnt_n;
  logic [7:0]                 r_dout,       w_dout_n;
  logic                       r_parity_err, w_parity_err_n;
  logic                       r_frame_err,  w_frame_err_n;
  logic                       r_done_tick,  w_done_tick_n;
  logic                       r_to_tick,    w_to_tick_n;

  ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk     (clk),
    .reset_n (reset_n),
    .ps2c    (ps2c),
    .filt_c  (),
    .fall    (w_fall)
  );

  assign w_data = r_d_sync[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_d_sync     <= '1;
      r_state      <= IDLE;
      r_bit_cnt    <= '0;
      r_sr         <= '0;
      r_to_cnt     <= '0;
      r_dout       <= '0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_done_tick  <= 1'b0;
      r_to_tick    <= 1'b0;
    end else begin
      r_d_sync     <= {r_d_sync[0], ps2d};
      r_state      <= w_state_n;
      r_bit_cnt    <= w_bit_cnt_n;
      r_sr         <= w_sr_n;
      r_to_cnt     <= w_to_cnt_n;
      r_dout       <= w_dout_n;
      r_parity_err <= w_parity_err_n;
      r_frame_err  <= w_frame_err_n;
      r_done_tick  <= w_done_tick_n;
      r_to_tick    <= w_to_tick_n;
    end
  end

  always_comb begin
    // NOTE: every target gets a default first, so no path can infer a latch.
    w_state_n      = r_state;
    w_bit_cnt_n    = r_bit_cnt;
    w_sr_n         = r_sr;
    w_to_cnt_n     = r_to_cnt;
    w_dout_n       = r_dout;
    w_parity_err_n = r_parity_err;
    w_frame_err_n  = r_frame_err;
    w_done_tick_n  = 1'b0;
    w_to_tick_n    = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_fall && rx_en && !w_data) begin
          w_state_n   = SHIFT;
          w_bit_cnt_n = '0;
          w_to_cnt_n  = '0;
        end
      end
      SHIFT: begin
        // A fall on the terminal count still wins over the timeout.
        if (w_fall) begin
          w_sr_n      = {w_data, r_sr[FRAME_DATA_BITS-1:1]};
          w_bit_cnt_n = r_bit_cnt + 4'd1;
          w_to_cnt_n  = '0;
          if (r_bit_cnt == STOP_CNT)
            w_state_n = DONE;
        end else if (r_to_cnt == TO_LAST) begin
          w_state_n   = IDLE;
          w_to_tick_n = 1'b1;
        end else begin
          w_to_cnt_n  = r_to_cnt + 1'b1;
        end
      end
      DONE: begin
        w_dout_n       = r_sr[7:0];
        w_parity_err_n = ~^r_sr[8:0];
        w_frame_err_n  = ~r_sr[STOP_IDX];
        w_done_tick_n  = 1'b1;
        w_state_n      = IDLE;
      end
      default: w_state_n = IDLE;
    endcase
  end

  assign dout         = r_dout;
  assign parity_err   = r_parity_err;
  assign frame_err    = r_frame_err;
  assign rx_done_tick = r_done_tick;
  assign timeout_tick = r_to_tick;
  assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_ps2_rx.sv
// Scoreboard bench for ps2_rx: random and directed PS/2 frames against a frame-level model.
module tb_ps2_rx;

  localparam int TIMEOUT = 2000;
  localparam int HALF    = 200;

  typedef struct {
    logic [7:0] dout;
    logic       perr;
    logic       ferr;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2c = 1'b1;
  logic       ps2d = 1'b1;
  logic       rx_en = 1'b0;
  logic [7:0] dout;
  logic       rx_done_tick, parity_err, frame_err, timeout_tick, busy;

  int   compared = 0;
  int   mismatched = 0;
  int   cyc = 0;
  int   last_drive = 0;
  int   to_cyc = 0;
  int   exp_to = 0;
  logic [7:0] model_dout = 8'h00;
  exp_t exp_q[$];
  exp_t mon_e;

  ps2_rx #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TIMEOUT), .TO_W(16)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .ps2c         (ps2c),
    .ps2d         (ps2d),
    .rx_en        (rx_en),
    .dout         (dout),
    .rx_done_tick (rx_done_tick),
    .parity_err   (parity_err),
    .frame_err    (frame_err),
    .timeout_tick (timeout_tick),
    .busy         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic odd_par(input logic [7:0] d);
    return ($countones(d) % 2) == 0;
  endfunction

  // Frame-level model: a byte is delivered only for a complete frame started with rx_en high.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                            input int nbits, input logic en, input bit flip_en);
    logic [10:0] bits;
    exp_t        e;
    bits  = {stp, par, d, 1'b0};
    rx_en = en;
    if (en && nbits == 11) begin
      e.dout = d;
      e.perr = ((($countones(d) + int'(par)) % 2) == 0);
      e.ferr = !stp;
      exp_q.push_back(e);
      model_dout = d;
    end
    for (int i = 0; i < nbits; i++) begin
      ps2d = bits[i];
      wait_cyc(HALF);
      ps2c = 1'b0;
      last_drive = cyc;
      wait_cyc(HALF);
      if (i == 1) check("busy_mid", busy, en);
      if (flip_en && i == 4) rx_en = ~rx_en;
      ps2c = 1'b1;
    end
    wait_cyc(HALF);
    ps2d = 1'b1;
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (rx_done_tick || timeout_tick)
        check("tick_excl", rx_done_tick & timeout_tick, 0);
      if (rx_done_tick) begin
        check("done_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("dout", dout, mon_e.dout);
          check("parity_err", parity_err, mon_e.perr);
          check("frame_err", frame_err, mon_e.ferr);
          check("done_lat", (cyc - last_drive >= 5) && (cyc - last_drive <= 30), 1);
        end
      end
      if (timeout_tick) begin
        check("to_expected", exp_to > 0, 1);
        if (exp_to > 0) exp_to--;
        to_cyc = cyc;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    logic       p, s, en;
    bit         flip, seen;
    int         drive;

    wait_cyc(5);
    check("rst_dout", dout, 0);
    check("rst_done", rx_done_tick, 0);
    check("rst_perr", parity_err, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_to", timeout_tick, 0);
    check("rst_busy", busy, 0);
    reset_n = 1'b1;
    wait_cyc(20);

    send_frame(8'h1C, odd_par(8'h1C), 1'b1, 11, 1'b1, 1'b0);
    wait_cyc(50);
    check("busy_after_1c", busy, 0);

    send_frame(8'h5A, ~odd_par(8'h5A), 1'b1, 11, 1'b1, 1'b0);
    wait_cyc(50);
    check("perr_hold", parity_err, 1);
    send_frame(8'hF0, odd_par(8'hF0), 1'b1, 11, 1'b1, 1'b0);
    wait_cyc(50);
    check("perr_cleared", parity_err, 0);

    send_frame(8'h29, odd_par(8'h29), 1'b0, 11, 1'b1, 1'b0);
    wait_cyc(50);
    check("ferr_hold", frame_err, 1);

    // Short low glitch on ps2c with data low looks like a start bit but must be filtered.
    ps2d = 1'b0;
    wait_cyc(10);
    ps2c = 1'b0;
    wait_cyc(5);
    ps2c = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      wait_cyc(1);
      if (busy) seen = 1'b1;
    end
    check("glitch_busy", seen, 0);
    ps2d = 1'b1;
    wait_cyc(20);

    send_frame(8'h3C, odd_par(8'h3C), 1'b1, 11, 1'b0, 1'b0);
    wait_cyc(50);

    exp_to = 1;
    send_frame(8'hAA, odd_par(8'hAA), 1'b1, 4, 1'b1, 1'b0);
    drive = last_drive;
    for (int i = 0; i < 2100 && exp_to != 0; i++) wait_cyc(1);
    check("timeout_fired", exp_to, 0);
    check("timeout_lat", (to_cyc - drive >= TIMEOUT) && (to_cyc - drive <= TIMEOUT + 40), 1);
    check("busy_after_to", busy, 0);
    check("dout_after_to", dout, model_dout);
    wait_cyc(TIMEOUT);

    send_frame(8'h76, odd_par(8'h76), 1'b1, 11, 1'b1, 1'b0);
    wait_cyc(50);

    send_frame(8'h34, odd_par(8'h34), 1'b1, 7, 1'b1, 1'b0);
    check("busy_before_rst", busy, 1);
    #3 reset_n = 1'b0;
    #1;
    check("arst_dout", dout, 0);
    check("arst_perr", parity_err, 0);
    check("arst_ferr", frame_err, 0);
    check("arst_busy", busy, 0);
    model_dout = 8'h00;
    wait_cyc(5);
    reset_n = 1'b1;
    wait_cyc(20);
    send_frame(8'h12, odd_par(8'h12), 1'b1, 11, 1'b1, 1'b0);
    wait_cyc(50);
    check("dout_12", dout, 8'h12);

    for (int n = 0; n < 6; n++) begin
      d  = 8'($urandom_range(0, 255));
      p  = odd_par(d);
      if ($urandom_range(0, 3) == 0) p = ~p;
      s  = ($urandom_range(0, 3) != 0);
      en = ($urandom_range(0, 4) != 0);
      flip = en && ($urandom_range(0, 1) == 1);
      send_frame(d, p, s, 11, en, flip);
      wait_cyc(50);
      check("busy_idle_rand", busy, 0);
      check("dout_rand", dout, model_dout);
    end

    wait_cyc(50);
    check("queue_empty", exp_q.size(), 0);
    check("to_pending", exp_to, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
